// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  typedef enum logic {RUN, FLUSH} state_e;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries
// Ports: clk, rst, push/wdata, pop/rdata, flush (clears all entries), count, full, empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign count = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rd_q];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    rd_d  = flush ? '0 : rd_q + AW'(do_pop);
    wr_d  = flush ? '0 : wr_q + AW'(do_push);
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with credit-limited imem requests and a small fetch buffer
// Ports: clk, rst (sync, active-high); imem_req_{valid,ready,addr}; imem_rsp_{valid,data};
//   redirect/redirect_pc; inst_{valid,ready}, instruction, inst_pc toward the decoder.
// FETCH_BYPASS_EN: a kept response reaches the decoder in the same cycle when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
  logic fifo_full, fifo_empty, accept, rsp_keep, bypass, push, pop;
  fetch_entry_t head;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wdata('{imem_rsp_data, rsp_pc_q}),
    .pop(pop), .rdata(head), .flush(redirect), .count(fifo_count),
    .full(fifo_full), .empty(fifo_empty)
  );
  assign imem_req_addr = req_pc_q;
  always_comb begin
    // Credits cover both in-flight requests and buffered words, so every response has a slot.
    imem_req_valid = !rst && state_q == RUN && !redirect && !fifo_full &&
                     (({1'b0, out_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    accept   = imem_req_valid && imem_req_ready;
    rsp_keep = imem_rsp_valid && drop_q == '0 && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass = rsp_keep && fifo_empty && inst_ready;
`else
    bypass = 1'b0;
`endif
    push        = rsp_keep && !bypass;
    inst_valid  = !fifo_empty || bypass;
    instruction = !fifo_empty ? head.instruction : bypass ? imem_rsp_data : NOP_INSN;
    inst_pc     = !fifo_empty ? head.pc : rsp_pc_q;
    pop         = inst_valid && inst_ready && !redirect;
    out_d       = out_q + CW'(accept) - CW'(imem_rsp_valid);
    // On redirect every request still in flight after this cycle's response must be discarded.
    drop_d   = redirect ? out_d : drop_q - CW'(imem_rsp_valid && drop_q != '0);
    req_pc_d = redirect ? align_pc(redirect_pc) : accept ? req_pc_q + 32'd4 : req_pc_q;
    rsp_pc_d = redirect ? align_pc(redirect_pc) : rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
    state_d  = drop_d != '0 ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end
endmodule
